// File: rtl/buf_inv_pkg.sv
// Shared types and helpers for the buf_inv_pipe lane transform pipeline.
package buf_inv_pkg;

  typedef enum logic [1:0] {
    MODE_BUF  = 2'b00,
    MODE_NOT  = 2'b01,
    MODE_ZERO = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  // Per-bit form of the lane transform so it stays independent of the lane width.
  function automatic logic xform_bit(input mode_e mode, input logic din, input logic last);
    case (mode)
      MODE_BUF:  return din;
      MODE_NOT:  return ~din;
      MODE_ZERO: return 1'b0;
      default:   return last;
    endcase
  endfunction

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/buf_inv_pipe_if.sv
// Producer/consumer/mode-programming bundle for buf_inv_pipe.
interface buf_inv_pipe_if
  import buf_inv_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int CHW = sel_width(CHANNELS);

  logic                      in_valid;
  logic                      in_ready;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic                      mode_we;
  logic [CHW-1:0]            mode_ch;
  logic [1:0]                mode_val;
  logic                      out_valid;
  logic                      out_ready;
  logic [CHANNELS*WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, mode_we, mode_ch, mode_val, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, mode_we, mode_ch, mode_val, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/buf_inv_pipe_stage.sv
// One elastic valid/ready register stage; data only changes when a new beat loads.
module pipe_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);
  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      // Leave data untouched on bubbles so an empty output keeps its last value.
      if (in_valid) data_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/buf_inv_pipe.sv
// Multi-lane programmable buffer/inverter feeding a DEPTH-stage elastic pipeline.
module buf_inv_pipe
  import buf_inv_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 2
) (
  input logic          clk,
  input logic          rstn,
  buf_inv_pipe_if.slave bus
);
  localparam int LW = CHANNELS * WIDTH;

  mode_e                  mode_q [CHANNELS];
  mode_e                  mode_d [CHANNELS];
  logic [WIDTH-1:0]       last_q [CHANNELS];
  logic [WIDTH-1:0]       last_d [CHANNELS];
  logic [LW-1:0]          xform_data;
  logic                   accept;
  logic [DEPTH:0]         stg_valid;
  logic [DEPTH:0]         stg_ready;
  logic [DEPTH:0][LW-1:0] stg_data;

  assign accept = bus.in_valid && bus.in_ready;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
    for (genvar gb = 0; gb < WIDTH; gb++) begin : g_bit
      assign xform_data[gi*WIDTH + gb] =
        xform_bit(mode_q[gi], bus.in_data[gi*WIDTH + gb], last_q[gi][gb]);
    end
  end

  // The beat accepted this edge sees mode_q, so a coincident write only affects later beats.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      mode_d[k] = mode_q[k];
      last_d[k] = last_q[k];
      if (accept) last_d[k] = xform_data[k*WIDTH +: WIDTH];
      if (bus.mode_we && int'(bus.mode_ch) == k) mode_d[k] = mode_e'(bus.mode_val);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < CHANNELS; k++) begin
        mode_q[k] <= MODE_BUF;
        last_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        mode_q[k] <= mode_d[k];
        last_q[k] <= last_d[k];
      end
    end
  end

  assign stg_valid[0]     = bus.in_valid;
  assign stg_data[0]      = xform_data;
  assign bus.in_ready     = stg_ready[0];
  assign stg_ready[DEPTH] = bus.out_ready;
  assign bus.out_valid    = stg_valid[DEPTH];
  assign bus.out_data     = stg_data[DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    pipe_stage #(.DW(LW)) u_stage (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (stg_valid[gi]),
      .in_ready  (stg_ready[gi]),
      .in_data   (stg_data[gi]),
      .out_valid (stg_valid[gi+1]),
      .out_ready (stg_ready[gi+1]),
      .out_data  (stg_data[gi+1])
    );
  end
endmodule

// File: tb/tb_buf_inv_pipe.sv
// Scoreboard bench for buf_inv_pipe: reference model predicts each accepted beat, a monitor checks outputs.
module tb_buf_inv_pipe;
  localparam int W  = 8;
  localparam int C  = 4;
  localparam int D  = 2;
  localparam int C3 = 3;
  localparam int D3 = 1;

  logic clk;
  logic rstn;
  int   cyc;
  int   n_checks;
  int   n_pass;
  int   n_acc;
  bit   lat_chk;

  logic [C*W-1:0] exp_q[$];
  int             acc_cyc_q[$];
  int             m_mode[C];
  logic [W-1:0]   m_last[C];
  logic [C*W-1:0] last_out;
  logic [C*W-1:0] held;
  bit             stalled;

  buf_inv_pipe_if #(.WIDTH(W), .CHANNELS(C))  bus ();
  buf_inv_pipe_if #(.WIDTH(W), .CHANNELS(C3)) bus3 ();

  buf_inv_pipe #(.WIDTH(W), .CHANNELS(C), .DEPTH(D)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  buf_inv_pipe #(.WIDTH(W), .CHANNELS(C3), .DEPTH(D3)) dut3 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: each lane is the input, its complement, zero, or the lane's previous output.
  function automatic logic [C*W-1:0] model_beat(input logic [C*W-1:0] din);
    logic [C*W-1:0] r;
    logic [W-1:0]   lane;
    for (int k = 0; k < C; k++) begin
      lane = din[k*W +: W];
      case (m_mode[k])
        0:       lane = lane;
        1:       lane = ~lane;
        2:       lane = '0;
        default: lane = m_last[k];
      endcase
      m_last[k]    = lane;
      r[k*W +: W]  = lane;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < C; k++) begin
      m_mode[k] = 0;
      m_last[k] = '0;
    end
    exp_q.delete();
    acc_cyc_q.delete();
  endtask

  // Predictor: accepted beat uses the modes before any write in the same cycle.
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model_beat(bus.in_data));
        acc_cyc_q.push_back(cyc);
        n_acc++;
      end
      if (bus.mode_we && int'(bus.mode_ch) < C) m_mode[bus.mode_ch] = int'(bus.mode_val);
    end
  end

  // Monitor: hold stability while stalled, then in-order data and optional latency.
  always @(negedge clk) begin
    if (!rstn) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", 64'(bus.out_valid), 64'd1);
        chk("stall_data", 64'(bus.out_data), 64'(held));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(bus.out_data), 64'hDEAD_0000_0000_0000);
        end else begin
          logic [C*W-1:0] e;
          int             ac;
          e  = exp_q.pop_front();
          ac = acc_cyc_q.pop_front();
          chk("out_data", 64'(bus.out_data), 64'(e));
          if (lat_chk) chk("latency", 64'(cyc - ac), 64'(D));
          last_out = bus.out_data;
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      held    = bus.out_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [C*W-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic set_mode(input int ch, input logic [1:0] m);
    bus.mode_we  = 1'b1;
    bus.mode_ch  = 2'(ch);
    bus.mode_val = m;
    step();
    bus.mode_we  = 1'b0;
  endtask

  task automatic drain(input string name);
    bus.in_valid  = 1'b0;
    bus.mode_we   = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    step();
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int acc0;
    n_checks = 0;
    n_pass   = 0;
    n_acc    = 0;
    cyc      = 0;
    lat_chk  = 1'b0;
    last_out = '0;
    model_reset();
    rstn          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.mode_we   = 1'b0;
    bus.mode_ch   = '0;
    bus.mode_val  = 2'b00;
    bus.out_ready = 1'b0;
    bus3.in_valid  = 1'b0;
    bus3.in_data   = '0;
    bus3.mode_we   = 1'b0;
    bus3.mode_ch   = '0;
    bus3.mode_val  = 2'b00;
    bus3.out_ready = 1'b1;

    repeat (3) step();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    rstn = 1'b1;
    step();

    // Streaming with consumer always ready: fixed latency, one beat per cycle.
    bus.out_ready = 1'b1;
    lat_chk = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 32'h01010101; step();
    bus.in_data = 32'h02020202; step();
    bus.in_data = 32'h03030303; step();
    bus.in_valid = 1'b0;
    drain("stream_drain");
    lat_chk = 1'b0;
    chk("stream_last", 64'(last_out), 64'h03030303);

    // Lane programming including HOLD of a previously sent value.
    send(32'hA5A5A5A5);
    set_mode(1, 2'b01);
    set_mode(2, 2'b10);
    set_mode(3, 2'b11);
    send(32'h3C3C3C3C);
    drain("prog_drain");
    chk("prog_lanes", 64'(last_out), 64'hA500C33C);
    for (int k = 1; k < C; k++) set_mode(k, 2'b00);

    // Mode write coincident with accept applies from the following beat.
    bus.mode_we  = 1'b1;
    bus.mode_ch  = 2'd0;
    bus.mode_val = 2'b01;
    send(32'h0F0F0F0F);
    bus.mode_we  = 1'b0;
    drain("same_cyc_drain1");
    chk("same_cyc_old_mode", 64'(last_out), 64'h0F0F0F0F);
    send(32'h0F0F0F0F);
    drain("same_cyc_drain2");
    chk("same_cyc_new_mode", 64'(last_out), 64'h0F0F0FF0);
    set_mode(0, 2'b00);

    // Backpressure: exactly DEPTH beats fit, then the input is refused.
    bus.out_ready = 1'b0;
    acc0 = n_acc;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_data = $urandom;
      step();
    end
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    chk("full_accepts", 64'(n_acc - acc0), 64'(D));
    bus.in_valid = 1'b0;
    drain("full_drain");

    // Asynchronous reset with beats in flight and a non-default mode.
    set_mode(2, 2'b01);
    bus.out_ready = 1'b0;
    send(32'h11223344);
    send(32'h55667788);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("async_rst_data", 64'(bus.out_data), 64'd0);
    model_reset();
    step();
    step();
    rstn = 1'b1;
    step();
    bus.out_ready = 1'b1;
    send(32'h55555555);
    drain("post_rst_drain");
    chk("post_rst_buf", 64'(last_out), 64'h55555555);

    // Randomized traffic, stalls and mode writes against the reference model.
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = $urandom;
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.mode_we   = ($urandom_range(0, 7) == 0);
      bus.mode_ch   = 2'($urandom_range(0, C - 1));
      bus.mode_val  = 2'($urandom_range(0, 3));
      step();
    end
    drain("random_drain");

    // Three-lane, single-stage instance: out-of-range lane writes are ignored.
    bus3.mode_we  = 1'b1;
    bus3.mode_ch  = 2'd3;
    bus3.mode_val = 2'b01;
    step();
    bus3.mode_we  = 1'b0;
    bus3.in_valid = 1'b1;
    bus3.in_data  = 24'hA5A5A5;
    step();
    bus3.in_valid = 1'b0;
    chk("ch3_oob_valid", 64'(bus3.out_valid), 64'd1);
    chk("ch3_oob_data", 64'(bus3.out_data), 64'hA5A5A5);
    bus3.mode_we  = 1'b1;
    bus3.mode_ch  = 2'd2;
    bus3.mode_val = 2'b01;
    step();
    bus3.mode_we  = 1'b0;
    bus3.in_valid = 1'b1;
    bus3.in_data  = 24'hA5A5A5;
    step();
    bus3.in_valid = 1'b0;
    chk("ch3_lane2_not", 64'(bus3.out_data), 64'h5AA5A5);
    step();
    chk("ch3_empty_valid", 64'(bus3.out_valid), 64'd0);
    chk("ch3_empty_hold", 64'(bus3.out_data), 64'h5AA5A5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
